gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 119 +++++++++++
 tb/tb_gate_sweep_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Exhaustive 2-input gate checker: walks {a,b} through 00,01,10,11, holds each
// vector SETTLE+1 cycles, samples gate_y on the last edge and compares it to EXPECT.
module gate_sweep_checker #(
    parameter logic [3:0]  EXPECT = 4'b0001,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [3:0] fail_mask
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] hold_cnt, hold_n;
    logic       armed, armed_n;
    logic       gate_a_n, gate_b_n, busy_n, done_n, pass_n;
    logic [2:0] fail_count_n;
    logic [3:0] fail_mask_n;
    logic       sample, miss;
    logic [2:0] count_upd;

    assign sample    = (state == HOLD) && (hold_cnt == HOLD_LAST);
    assign miss      = sample && (gate_y != EXPECT[idx]);
    assign count_upd = (miss && (fail_count != 3'd4)) ? fail_count + 3'd1 : fail_count;

    // start must be seen low after an accepted run before another run is taken,
    // so a level held high across the whole sweep yields exactly one sweep
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        hold_n       = hold_cnt;
        armed_n      = armed | ~start;
        gate_a_n     = gate_a;
        gate_b_n     = gate_b;
        busy_n       = busy;
        done_n       = 1'b0;
        pass_n       = pass;
        fail_count_n = fail_count;
        fail_mask_n  = fail_mask;
        case (state)
            IDLE: begin
                busy_n   = 1'b0;
                gate_a_n = 1'b0;
                gate_b_n = 1'b0;
                if (start && armed) begin
                    state_n      = HOLD;
                    idx_n        = 2'd0;
                    hold_n       = 4'd0;
                    fail_count_n = 3'd0;
                    fail_mask_n  = 4'd0;
                    pass_n       = 1'b0;
                    busy_n       = 1'b1;
                    armed_n      = 1'b0;
                end
            end
            HOLD: begin
                if (sample) begin
                    fail_count_n = count_upd;
                    if (miss) fail_mask_n[idx] = 1'b1;
                    if (idx == 2'd3) begin
                        state_n  = DONE;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        pass_n   = (count_upd == 3'd0);
                        gate_a_n = 1'b0;
                        gate_b_n = 1'b0;
                    end else begin
                        idx_n                = idx + 2'd1;
                        hold_n               = 4'd0;
                        {gate_a_n, gate_b_n} = idx + 2'd1;
                    end
                end else begin
                    hold_n = hold_cnt + 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            hold_cnt   <= 4'd0;
            armed      <= 1'b1;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 3'd0;
            fail_mask  <= 4'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            hold_cnt   <= hold_n;
            armed      <= armed_n;
            gate_a     <= gate_a_n;
            gate_b     <= gate_b_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            fail_count <= fail_count_n;
            fail_mask  <= fail_mask_n;
        end
    end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: two checkers (SETTLE=1, SETTLE=0) driven by a behavioural gate
// model; predicted sweep results are queued at start and popped at done.
module tb_gate_sweep_checker;
    localparam logic [3:0] NOR_TT = 4'b0001;
    localparam int M_NOR = 0, M_OR = 1, M_ST0 = 2;

    typedef struct packed {
        logic       pass;
        logic [2:0] cnt;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [2];
    logic       a_v [2], b_v [2], y_v [2];
    logic       busy_v [2], done_v [2], pass_v [2];
    logic [2:0] cnt_v [2];
    logic [3:0] mask_v [2];
    int         mode = M_NOR;
    int         n_assert = 0, n_fail = 0;
    exp_t       sb [$];

    always #5 clk = ~clk;

    function automatic logic gate_model(input int md, input logic a, input logic b);
        case (md)
            M_NOR:   return ~(a | b);
            M_OR:    return a | b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        y_v[0] = gate_model(mode, a_v[0], b_v[0]);
        y_v[1] = gate_model(mode, a_v[1], b_v[1]);
    end

    gate_sweep_checker #(.EXPECT(NOR_TT), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .gate_a(a_v[0]), .gate_b(b_v[0]), .gate_y(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .fail_count(cnt_v[0]), .fail_mask(mask_v[0])
    );

    gate_sweep_checker #(.EXPECT(NOR_TT), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .gate_a(a_v[1]), .gate_b(b_v[1]), .gate_y(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .fail_count(cnt_v[1]), .fail_mask(mask_v[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t predict(input int md);
        exp_t       e;
        logic [1:0] v;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (gate_model(md, v[1], v[0]) != NOR_TT[i]) begin
                e.mask[i] = 1'b1;
                e.cnt     = e.cnt + 3'd1;
            end
        end
        e.pass = (e.cnt == 3'd0);
        return e;
    endfunction

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, " busy"}, 8'(busy_v[d]), 8'd0);
        chk({tag, " done"}, 8'(done_v[d]), 8'd0);
        chk({tag, " pass"}, 8'(pass_v[d]), 8'd0);
        chk({tag, " cnt"},  8'(cnt_v[d]),  8'd0);
        chk({tag, " mask"}, 8'(mask_v[d]), 8'd0);
        chk({tag, " ab"},   8'({a_v[d], b_v[d]}), 8'd0);
    endtask

    // d selects the instance (0: SETTLE=1, 1: SETTLE=0); slen = cycles start is held
    task automatic run_sweep(input int d, input int md, input int slen);
        int   win, total, dones, last;
        exp_t e, got;
        mode  = md;
        win   = (d == 0) ? 2 : 1;
        total = 4 * win;
        e     = predict(md);
        sb.push_back(e);
        dones = 0;
        last  = (total + 4 > slen + 3) ? total + 4 : slen + 3;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= last; m++) begin
            @(negedge clk);
            if (m == slen - 1) start_v[d] = 1'b0;
            if (done_v[d] === 1'b1) dones++;
            if (m < total) begin
                chk($sformatf("d%0d md%0d busy m=%0d", d, md, m), 8'(busy_v[d]), 8'd1);
                chk($sformatf("d%0d md%0d done m=%0d", d, md, m), 8'(done_v[d]), 8'd0);
                chk($sformatf("d%0d md%0d ab m=%0d", d, md, m), 8'({a_v[d], b_v[d]}), 8'(m / win));
            end else if (m == total) begin
                chk($sformatf("d%0d md%0d done pulse", d, md), 8'(done_v[d]), 8'd1);
                chk($sformatf("d%0d md%0d busy at done", d, md), 8'(busy_v[d]), 8'd0);
                chk($sformatf("d%0d md%0d ab at done", d, md), 8'({a_v[d], b_v[d]}), 8'd0);
                got = (sb.size() > 0) ? sb.pop_front() : '1;
                chk($sformatf("d%0d md%0d pass", d, md), 8'(pass_v[d]), 8'(got.pass));
                chk($sformatf("d%0d md%0d fail_count", d, md), 8'(cnt_v[d]), 8'(got.cnt));
                chk($sformatf("d%0d md%0d fail_mask", d, md), 8'(mask_v[d]), 8'(got.mask));
            end else begin
                chk($sformatf("d%0d md%0d idle busy m=%0d", d, md, m), 8'(busy_v[d]), 8'd0);
                chk($sformatf("d%0d md%0d hold result m=%0d", d, md, m),
                    {pass_v[d], cnt_v[d], mask_v[d]}, e);
            end
        end
        start_v[d] = 1'b0;
        chk($sformatf("d%0d md%0d done pulses", d, md), 8'(dones), 8'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        #1;
        chk_idle_zero(0, "reset s1");
        chk_idle_zero(1, "reset s0");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, M_NOR, 1);
        run_sweep(0, M_OR, 1);
        run_sweep(0, M_ST0, 1);
        run_sweep(0, M_NOR, 20);

        // reset pulsed while vector 10 is on the gate
        mode = M_NOR;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= 4; m++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        chk("pre-reset ab", 8'({a_v[0], b_v[0]}), 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_zero(0, "async reset");
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            chk($sformatf("in reset done m=%0d", m), 8'(done_v[0]), 8'd0);
        end
        rst_n = 1'b1;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            chk($sformatf("post-reset no done m=%0d", m), 8'({busy_v[0], done_v[0]}), 8'd0);
        end
        run_sweep(0, M_NOR, 1);

        run_sweep(1, M_NOR, 1);
        run_sweep(1, M_OR, 1);

        chk("scoreboard empty", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
